axis_skid: RTL and testbench



---
 rtl/axis_skid.sv | 157 +++++++++++++++
 tb/tb_axis_skid.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_skid.sv
// axis_skid: AXI-Stream backward-path register slice (skid buffer).
// Upstream tready is always driven straight from a flop.
// Build option: define AXIS_SKID_FWD_REG_EN for full mode. That mode also
// registers tvalid/tdata, giving a two-entry slice with 1-cycle latency.
// Without the macro the slice is skid-only: a 1-entry skid with a
// combinational forward path and 0-cycle latency.
module axis_skid #(
  parameter int TDATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_sif_tvalid,
  input  logic [TDATA_WIDTH-1:0] i_sif_tdata,
  output logic                   o_sif_tready,
  output logic                   o_mif_tvalid,
  output logic [TDATA_WIDTH-1:0] o_mif_tdata,
  input  logic                   i_mif_tready,
  input  logic                   i_invalidate
);

  if (TDATA_WIDTH <= 0) begin : g_width_check
    $fatal(1, "axis_skid: TDATA_WIDTH must be > 0");
  end

  logic w_accept;
  logic w_emit;

`ifdef AXIS_SKID_FWD_REG_EN

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [TDATA_WIDTH-1:0] r_main;
  logic [TDATA_WIDTH-1:0] r_skid;
  logic [TDATA_WIDTH-1:0] w_main_next;
  logic [TDATA_WIDTH-1:0] w_skid_next;
  logic                   r_sif_tready;
  logic                   r_mif_tvalid;

  assign w_accept = i_sif_tvalid && r_sif_tready;
  assign w_emit   = r_mif_tvalid && i_mif_tready;

  // State register: FSM state, both data entries, and the pre-decoded handshake flops
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_EMPTY;
      r_main       <= '0;
      r_skid       <= '0;
      r_sif_tready <= 1'b1;
      r_mif_tvalid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_main       <= w_main_next;
      r_skid       <= w_skid_next;
      r_sif_tready <= (w_state_next != ST_FULL);
      r_mif_tvalid <= (w_state_next != ST_EMPTY);
    end
  end

  // Next-state logic: invalidate overrides every transition and leaves the data untouched
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (i_invalidate) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_BUSY;
            w_main_next  = i_sif_tdata;
          end
        end
        ST_BUSY: begin
          if (w_accept && !w_emit) begin
            w_state_next = ST_FULL;
            w_skid_next  = i_sif_tdata;
          end else if (!w_accept && w_emit) begin
            w_state_next = ST_EMPTY;
          end else if (w_accept && w_emit) begin
            w_main_next  = i_sif_tdata;
          end
        end
        ST_FULL: begin
          if (w_emit) begin
            w_state_next = ST_BUSY;
            w_main_next  = r_skid;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // Output logic: every output comes straight from a register
  always_comb begin
    o_sif_tready = r_sif_tready;
    o_mif_tvalid = r_mif_tvalid;
    o_mif_tdata  = r_main;
  end

`else

  logic                   r_skid_valid;
  logic [TDATA_WIDTH-1:0] r_skid_data;
  logic                   r_sif_tready;
  logic                   w_skid_valid_next;
  logic [TDATA_WIDTH-1:0] w_skid_data_next;
  logic                   w_mif_tvalid;

  assign w_mif_tvalid = r_skid_valid || i_sif_tvalid;
  assign w_accept     = i_sif_tvalid && r_sif_tready;
  assign w_emit       = w_mif_tvalid && i_mif_tready;

  // Skid next-state: catch a beat accepted while downstream stalls, release it on emit
  always_comb begin
    w_skid_valid_next = r_skid_valid;
    w_skid_data_next  = r_skid_data;
    if (i_invalidate) begin
      w_skid_valid_next = 1'b0;
    end else if (w_accept && !i_mif_tready) begin
      w_skid_valid_next = 1'b1;
      w_skid_data_next  = i_sif_tdata;
    end else if (w_emit && r_skid_valid) begin
      w_skid_valid_next = 1'b0;
    end
  end

  // Skid registers; tready is a separate flop mirroring !skid_valid so it has no logic after it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_sif_tready <= 1'b1;
    end else begin
      r_skid_valid <= w_skid_valid_next;
      r_skid_data  <= w_skid_data_next;
      r_sif_tready <= !w_skid_valid_next;
    end
  end

  // Output logic: the skid beat has priority, otherwise the upstream beat passes through
  always_comb begin
    o_sif_tready = r_sif_tready;
    o_mif_tvalid = w_mif_tvalid;
    o_mif_tdata  = r_skid_valid ? r_skid_data : i_sif_tdata;
  end

`endif

endmodule

// File: tb/tb_axis_skid.sv
// tb_axis_skid: self-checking bench for axis_skid (works in both build modes).
module tb_axis_skid;

  localparam int W = 8;

`ifdef AXIS_SKID_FWD_REG_EN
  localparam bit FULL_MODE = 1'b1;
`else
  localparam bit FULL_MODE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sv = 1'b0;
  logic [W-1:0] sd = '0;
  logic         mr = 1'b0;
  logic         inv = 1'b0;
  logic         sr;
  logic         mv;
  logic [W-1:0] md;

  int total = 0;
  int bad   = 0;

  axis_skid #(.TDATA_WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sif_tvalid (sv),
    .i_sif_tdata  (sd),
    .o_sif_tready (sr),
    .o_mif_tvalid (mv),
    .o_mif_tdata  (md),
    .i_mif_tready (mr),
    .i_invalidate (inv)
  );

  always #5 clk = ~clk;

  // Upstream tready may only change right at a rising edge
  time t_edge = 0;
  always @(posedge clk) t_edge = $time;
  always @(sr) begin
    if ($time != 0 && $time != t_edge) begin
      total++;
      bad++;
      $display("FAIL sif_tready_glitch: changed at t=%0t, last edge t=%0t", $time, t_edge);
    end
  end

  typedef struct {
    logic         sv;
    logic [W-1:0] sd;
    logic         mr;
    logic         inv;
    logic         exp_sr;
    logic         exp_mv;
    logic [W-1:0] exp_md;
    logic         chk_md;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic outs(input string name, input logic esr, input logic emv, input logic [W-1:0] emd);
    chk({name, ".sif_tready"}, 32'(sr), 32'(esr));
    chk({name, ".mif_tvalid"}, 32'(mv), 32'(emv));
    if (emv) chk({name, ".mif_tdata"}, 32'(md), 32'(emd));
  endtask

  // Drive one cycle's inputs at the falling edge, then let combinational outputs settle
  task automatic step(input logic a_sv, input logic [W-1:0] a_sd, input logic a_mr, input logic a_inv);
    @(negedge clk);
    sv = a_sv; sd = a_sd; mr = a_mr; inv = a_inv;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sv = 1'b0; sd = '0; mr = 1'b0; inv = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  logic [W-1:0] q[$];
  int accepted;
  int cycles;
  logic esr, emv, acc, em;
  logic [W-1:0] emd;

  initial begin
    // Streaming table: 8 beats 0..7 with downstream always ready, plus one idle cycle
    for (int k = 0; k < 9; k++) begin
      vecs[k].sv     = (k < 8);
      vecs[k].sd     = W'(k);
      vecs[k].mr     = 1'b1;
      vecs[k].inv    = 1'b0;
      vecs[k].exp_sr = 1'b1;
      if (FULL_MODE) begin
        vecs[k].exp_mv = (k > 0);
        vecs[k].exp_md = W'(k - 1);
        vecs[k].chk_md = (k > 0);
      end else begin
        vecs[k].exp_mv = (k < 8);
        vecs[k].exp_md = W'(k);
        vecs[k].chk_md = (k < 8);
      end
    end

    do_reset();
    chk("reset.sif_tready", 32'(sr), 32'(1));
    chk("reset.mif_tvalid", 32'(mv), 32'(0));
    chk("reset.mif_tdata", 32'(md), 32'(0));

    for (int k = 0; k < 9; k++) begin
      step(vecs[k].sv, vecs[k].sd, vecs[k].mr, vecs[k].inv);
      $display("stream vec %0d: in v=%0d d=%02h -> ready=%0d out v=%0d d=%02h",
               k, vecs[k].sv, vecs[k].sd, sr, mv, md);
      chk($sformatf("stream%0d.sif_tready", k), 32'(sr), 32'(vecs[k].exp_sr));
      chk($sformatf("stream%0d.mif_tvalid", k), 32'(mv), 32'(vecs[k].exp_mv));
      if (vecs[k].chk_md) chk($sformatf("stream%0d.mif_tdata", k), 32'(md), 32'(vecs[k].exp_md));
    end

    // Stall capture: A5 accepted as downstream stalls, A6 offered behind it
    do_reset();
    if (FULL_MODE) begin
      step(1, 8'hA5, 0, 0); outs("stall0", 1, 0, 8'h00);
      step(1, 8'hA6, 0, 0); outs("stall1", 1, 1, 8'hA5);
      step(0, 8'h00, 1, 0); outs("stall2", 0, 1, 8'hA5);
      step(0, 8'h00, 1, 0); outs("stall3", 1, 1, 8'hA6);
      step(0, 8'h00, 1, 0); outs("stall4", 1, 0, 8'h00);
    end else begin
      step(1, 8'hA5, 0, 0); outs("stall0", 1, 1, 8'hA5);
      step(1, 8'hA6, 0, 0); outs("stall1", 0, 1, 8'hA5);
      step(1, 8'hA6, 1, 0); outs("stall2", 0, 1, 8'hA5);
      step(1, 8'hA6, 1, 0); outs("stall3", 1, 1, 8'hA6);
      step(0, 8'h00, 1, 0); outs("stall4", 1, 0, 8'h00);
    end

    // Flush: held beats must never appear downstream
    do_reset();
    if (FULL_MODE) begin
      step(1, 8'h11, 0, 0);
      step(1, 8'h22, 0, 0);
      step(0, 8'h00, 0, 1); outs("flush_full", 0, 1, 8'h11);
      step(0, 8'h00, 1, 0); outs("flush_after", 1, 0, 8'h00);
    end else begin
      step(1, 8'h11, 0, 0);
      step(0, 8'h00, 0, 1); outs("flush_held", 0, 1, 8'h11);
      step(0, 8'h00, 1, 0); outs("flush_after", 1, 0, 8'h00);
    end
    for (int k = 0; k < 3; k++) begin
      step(0, 8'h00, 1, 0);
      chk($sformatf("flush_drain%0d.mif_tvalid", k), 32'(mv), 32'(0));
    end

    // Reset while holding beats, then one beat 3C must flow normally
    do_reset();
    step(1, 8'h44, 0, 0);
    if (FULL_MODE) begin
      step(1, 8'h55, 0, 0);
      step(0, 8'h00, 0, 0); outs("prereset_full", 0, 1, 8'h44);
    end else begin
      step(0, 8'h00, 0, 0); outs("prereset_held", 0, 1, 8'h44);
    end
    @(negedge clk); rst_n = 1'b0; sv = 1'b0; sd = '0; mr = 1'b0; #1;
    @(negedge clk); #1;
    chk("midreset.sif_tready", 32'(sr), 32'(1));
    chk("midreset.mif_tvalid", 32'(mv), 32'(0));
    chk("midreset.mif_tdata", 32'(md), 32'(0));
    rst_n = 1'b1;
    if (FULL_MODE) begin
      step(1, 8'h3C, 1, 0); outs("post_reset0", 1, 0, 8'h00);
      step(0, 8'h00, 1, 0); outs("post_reset1", 1, 1, 8'h3C);
      step(0, 8'h00, 1, 0); outs("post_reset2", 1, 0, 8'h00);
    end else begin
      step(1, 8'h3C, 1, 0); outs("post_reset0", 1, 1, 8'h3C);
      step(0, 8'h00, 1, 0); outs("post_reset1", 1, 0, 8'h00);
    end

    // Random traffic against a queue-occupancy reference model
    do_reset();
    q.delete();
    accepted = 0;
    cycles   = 0;
    while (accepted < 1000 && cycles < 20000) begin
      step($urandom_range(0, 1) == 1, W'($urandom_range(0, 255)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
      if (FULL_MODE) begin
        esr = (q.size() < 2);
        emv = (q.size() > 0);
      end else begin
        esr = (q.size() == 0);
        emv = (q.size() > 0) || sv;
      end
      emd = (q.size() > 0) ? q[0] : sd;
      chk($sformatf("rand%0d.sif_tready", cycles), 32'(sr), 32'(esr));
      chk($sformatf("rand%0d.mif_tvalid", cycles), 32'(mv), 32'(emv));
      if (emv) chk($sformatf("rand%0d.mif_tdata", cycles), 32'(md), 32'(emd));
      acc = sv && esr;
      em  = emv && mr;
      if (acc) begin
        q.push_back(sd);
        accepted++;
      end
      if (em) begin
        $display("rand cycle %0d: emit %02h", cycles, emd);
        void'(q.pop_front());
      end
      if (inv) q.delete();
      cycles++;
    end
    chk("rand.beats_accepted", 32'(accepted), 32'(1000));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
